// File: rtl/mem_1r1w_fifo_pkg.sv
// Shared constants and data type for the mem_1r1w FIFO controller and the
// parent that instantiates the 32x64 macro wrapper.
package mem_1r1w_pkg;
    localparam int DEPTH = 32;
    localparam int WIDTH = 64;
    localparam int AW    = 5;
    localparam int CW    = 6;

    // Memory occupancy at which the macro is full (enq_ready drops).
    localparam logic [AW:0] MEM_FULL = DEPTH[AW:0];

    typedef logic [WIDTH-1:0] data_t;
endpackage

// File: rtl/mem_1r1w_fifo_if.sv
// Producer/consumer handshake bundle of the FIFO plus its occupancy count.
interface mem_1r1w_fifo_if;
    import mem_1r1w_pkg::*;

    logic               enq_valid;
    logic               enq_ready;
    data_t              enq_bits;
    logic               deq_valid;
    logic               deq_ready;
    data_t              deq_bits;
    logic [CW-1:0]      count;

    // FIFO side
    modport slave (
        input  enq_valid, enq_bits, deq_ready,
        output enq_ready, deq_valid, deq_bits, count
    );

    // Producer/consumer side
    modport master (
        output enq_valid, enq_bits, deq_ready,
        input  enq_ready, deq_valid, deq_bits, count
    );
endinterface

// File: rtl/mem_1r1w_fifo_out_buf.sv
// Two-entry in-order register queue sitting in front of the consumer.
// Head is always slot 0, so dout_o is a plain register output.
module fifo_out_buf
    import mem_1r1w_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push_i,
    input  data_t      din_i,
    input  logic       pop_i,
    output data_t      dout_o,
    output logic [1:0] cnt_o
);
    data_t      d0_q, d0_d;
    data_t      d1_q, d1_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] cnt_after_pop;

    // Pop shifts slot 1 into the head, then a push lands in the first free slot.
    always_comb begin
        d0_d          = d0_q;
        d1_d          = d1_q;
        cnt_after_pop = cnt_q - {1'b0, pop_i};
        if (pop_i) d0_d = d1_q;
        if (push_i) begin
            if (cnt_after_pop == 2'd0) d0_d = din_i;
            else                       d1_d = din_i;
        end
        cnt_d = cnt_after_pop + {1'b0, push_i};
    end

    // Storage and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d0_q  <= '0;
            d1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            d0_q  <= d0_d;
            d1_q  <= d1_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout_o = d0_q;
    assign cnt_o  = cnt_q;
endmodule

// File: rtl/mem_1r1w_fifo.sv
// First-word-fall-through FIFO controller around an external 1R1W macro.
// Pointers and counters live here; a 2-entry output buffer hides the
// macro's one-cycle read latency so the consumer sees registered data.
module mem_1r1w_fifo
    import mem_1r1w_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    mem_1r1w_fifo_if.slave    io,
    output logic [AW-1:0]     R0_addr,
    output logic              R0_en,
    output logic              R0_clk,
    input  data_t             R0_data,
    output logic [AW-1:0]     W0_addr,
    output logic              W0_en,
    output logic              W0_clk,
    output data_t             W0_data
);
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   mem_cnt_q, mem_cnt_d;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] count_q, count_d;

    logic          enq_fire, deq_fire;
    logic          bypass, mem_wr, mem_rd;
    logic [1:0]    ob_cnt;
    logic [2:0]    ob_free_chk;
    logic [2:0]    ob_pend_chk;
    logic          ob_push;
    data_t         ob_din;
    data_t         ob_head;

    // Handshake, bypass and read-issue decisions from registered state.
    always_comb begin
        enq_fire    = io.enq_valid && io.enq_ready;
        deq_fire    = io.deq_valid && io.deq_ready;
        // deq_fire implies ob_cnt>=1, so neither subtraction underflows.
        ob_free_chk = {1'b0, ob_cnt} - {2'b0, deq_fire};
        ob_pend_chk = {1'b0, ob_cnt} + {2'b0, inflight_q} - {2'b0, deq_fire};
        // Bypass only when nothing older is queued in the memory or in flight.
        bypass      = enq_fire && (mem_cnt_q == '0) && !inflight_q && (ob_free_chk < 3'd2);
        mem_wr      = enq_fire && !bypass;
        mem_rd      = (mem_cnt_q != '0) && (ob_pend_chk < 3'd2);
        // Bypass needs !inflight, so at most one of these pushes per cycle.
        ob_push     = bypass || inflight_q;
        ob_din      = inflight_q ? R0_data : io.enq_bits;
    end

    // Next-state for pointers, occupancy and the total count.
    always_comb begin
        rd_ptr_d   = rd_ptr_q + {{(AW-1){1'b0}}, mem_rd};
        wr_ptr_d   = wr_ptr_q + {{(AW-1){1'b0}}, mem_wr};
        mem_cnt_d  = mem_cnt_q + {{AW{1'b0}}, mem_wr} - {{AW{1'b0}}, mem_rd};
        inflight_d = mem_rd;
        count_d    = count_q + {{(CW-1){1'b0}}, enq_fire} - {{(CW-1){1'b0}}, deq_fire};
    end

    // Controller state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
        end
    end

    fifo_out_buf u_ob (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (ob_push),
        .din_i   (ob_din),
        .pop_i   (deq_fire),
        .dout_o  (ob_head),
        .cnt_o   (ob_cnt)
    );

    // enq_ready depends only on registered memory occupancy.
    assign io.enq_ready = (mem_cnt_q < MEM_FULL);
    assign io.deq_valid = (ob_cnt != 2'd0);
    assign io.deq_bits  = ob_head;
    assign io.count     = count_q;

    assign R0_addr = rd_ptr_q;
    assign R0_en   = mem_rd;
    assign R0_clk  = clock;
    assign W0_addr = wr_ptr_q;
    assign W0_en   = mem_wr;
    assign W0_clk  = clock;
    assign W0_data = io.enq_bits;
endmodule
